pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the ARC MIPS fetch stage. It holds the fetch PC, which can be stalled, redirected or halted. It supports the reset vector, exception vector and branch/jump redirects, and has an optional return-address stack (RAS) that predicts `jr $ra` targets. It drives the instruction-memory address and a fetch-valid qualifier to IF.

## Interface
- `AW`, 32: PC width in bits (≥ 8).
- `RESET_VEC`, `32'hBFC0_0000`: PC loaded on reset (truncated to `AW`).
- `EXC_VEC`, `32'hBFC0_0380`: exception entry PC.
- `RAS_DEPTH`, 4: RAS entries (power of two, ≥ 2); used only with `PC_GEN_RAS_EN`.

Ports:
- `i_clk`, in, 1: clock; all state on its rising edge.
- `i_rst`, in, 1: asynchronous, active-high reset.
- `i_stall`, in, 1: hold PC (hazard/IMEM wait).
- `i_halt`, in, 1: enter HALT.
- `i_resume`, in, 1: leave HALT.
- `i_exc`, in, 1: exception; jump to `EXC_VEC`.
- `i_redir_valid`, in, 1: resolved branch/jump redirect.
- `i_redir_pc`, in, `AW`: redirect target.
- `i_call`, in, 1: push `i_call_ra` onto RAS (JAL/JALR in ID).
- `i_call_ra`, in, `AW`: return address to push.
- `i_ret`, in, 1: `jr $ra` in ID; predict from RAS.
- `o_pc`, out, `AW`: current fetch PC.
- `o_pc_plus4`, out, `AW`: `o_pc + 4`, modulo 2^`AW`.
- `o_fetch_valid`, out, 1: `o_pc` is a real fetch.
- `o_ras_miss`, out, 1: one-cycle pulse when a return found the RAS empty.
- `o_misalign`, out, 1: one-cycle pulse when a redirect target had bits[1:0] ≠ 0.

## Operation
- The FSM has three states: BOOT, RUN and HALT. Reset forces BOOT.
  - BOOT → RUN unconditionally after one cycle. `o_fetch_valid` = 0 in BOOT.
  - RUN → HALT when `i_halt` = 1 and there is no `i_exc`/`i_redir_valid` that cycle.
  - HALT → RUN on `i_resume` or `i_exc`. PC is held in HALT.
- Next-PC priority, highest first:
  1. `i_exc` → `EXC_VEC`.
  2. `i_redir_valid` → `{i_redir_pc[AW-1:2], 2'b00}`.
  3. `i_stall`, or state HALT/BOOT, → hold.
  4. `i_ret` with RAS non-empty → RAS top.
  5. Otherwise → `o_pc + 4`.
- `i_exc` and `i_redir_valid` override stall and HALT. Rows 4–5 obey stall.
- Increment wraps: `{AW{1'b1}} & ~3` + 4 → 0.
- `o_misalign` pulses only when the redirect is actually taken.
- RAS (macro on):
  - Circular buffer with a pointer and an occupancy count (0..`RAS_DEPTH`).
  - Push when full overwrites the oldest entry; count saturates.
  - Pop when empty: PC goes sequential, `o_ras_miss` = 1, count stays 0.
  - Call and return in the same cycle: the return reads the old top; the new entry replaces it; count is unchanged.
  - Push and pop are suppressed under `i_stall` unless `i_exc`/`i_redir_valid` is also asserted.
  - `i_exc` leaves the RAS contents unchanged.

## Timing
- All outputs are registered, except `o_pc_plus4`, which is combinational from `o_pc`.
- Outputs during and immediately after reset:
  - `o_pc` = `RESET_VEC`; `o_fetch_valid` = 0; `o_ras_miss` = 0; `o_misalign` = 0; RAS count = 0.
- First valid fetch: `o_pc` = `RESET_VEC` with `o_fetch_valid` = 1 in the second cycle after `i_rst` falls.
- Redirect or exception sampled at edge N → new `o_pc` visible after edge N (one-cycle latency).
- RAS prediction has the same one-cycle latency.
- `i_rst` asserted mid-operation clears state immediately, without waiting for a clock edge.
- `o_fetch_valid` = 1 only in RUN. It stays 1 during stall; IF qualifies stall separately.

## Configuration
- `PC_GEN_RAS_EN` defined: RAS is instantiated, `i_ret` prediction is active, and `o_ras_miss` is live.
- `PC_GEN_RAS_EN` undefined:
  - No RAS storage.
  - `i_call`, `i_call_ra` and `i_ret` are ignored.
  - `o_ras_miss` is tied to 0.
  - Priority row 4 is removed.
  - Ports remain present.

## Structure
- Shared package `arc_pkg`:
  - FSM enum `pc_state_t` (BOOT, RUN, HALT).
  - Default `RESET_VEC`/`EXC_VEC` constants.
  - `PC_INC` = 4.
- Sub-module `ras`: a circular stack with push/pop/top/empty/full interface, parametrised by `AW` and `RAS_DEPTH`. It is instantiated under `PC_GEN_RAS_EN`.

## Test plan
- Reset, then release → `o_pc` = `BFC00000` with `o_fetch_valid` = 0 for one cycle, then 1. Subsequent PCs are `BFC00004`, `BFC00008`.
- `i_stall` for 3 cycles at PC `BFC00010` → PC holds 3 cycles, then `BFC00014`. `i_redir_valid` (`i_redir_pc` = `00400002`) during stall → next PC `00400000` and `o_misalign` pulses.
- `i_exc` and `i_redir_valid` in the same cycle → next PC `BFC00380`. In HALT, `i_exc` → RUN at `BFC00380`.
- `AW` = 8, PC `FC` → next PC `00`.
- RAS (depth 4):
  - Push `100`, `200`, `300`, `400`, `500`, then 5 `i_ret` → targets `500`, `400`, `300`, `200`; the 5th return goes sequential with `o_ras_miss` = 1.
  - Simultaneous call(`600`)+ret with top `200` → target `200`; new top `600`.
- Assert `i_rst` mid-stream with RAS non-empty → immediately `o_pc` = `RESET_VEC`. The next `i_ret` misses.

Source files
------------

// File: rtl/arc_pkg.sv
// ============================================================================
// Module : arc_pkg
// Brief  : Shared types and constants for the ARC MIPS fetch front end.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arc_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } pc_state_t;

   localparam logic [31:0] DEFAULT_RESET_VEC = 32'hBFC0_0000;
   localparam logic [31:0] DEFAULT_EXC_VEC   = 32'hBFC0_0380;
   localparam logic [31:0] PC_INC            = 32'd4;

endpackage : arc_pkg

`default_nettype wire

// File: rtl/ras.sv
// ============================================================================
// Module : ras
// Brief  : Circular return-address stack; a push when full drops the oldest.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ras #(
   parameter int AW        = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [AW-1:0] i_data,
   output logic [AW-1:0] o_top,
   output logic          o_empty,
   output logic          o_full
);

   localparam int               c_pw      = $clog2(RAS_DEPTH);
   localparam logic [c_pw-1:0]  c_ptr_one = 1;
   localparam logic [c_pw:0]    c_cnt_one = 1;
   localparam logic [c_pw:0]    c_cnt_max = (c_pw+1)'(RAS_DEPTH);

   logic [AW-1:0]   r_mem [RAS_DEPTH];
   logic [c_pw-1:0] r_ptr;
   logic [c_pw:0]   r_cnt;
   logic [c_pw-1:0] w_ptr_inc;
   logic [c_pw-1:0] w_ptr_dec;
   logic            w_pop_ok;

   assign w_ptr_inc = r_ptr + c_ptr_one;
   assign w_ptr_dec = r_ptr - c_ptr_one;
   assign w_pop_ok  = i_pop && !o_empty;
   assign o_top     = r_mem[r_ptr];
   assign o_empty   = (r_cnt == '0);
   assign o_full    = (r_cnt == c_cnt_max);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ptr <= '0;
         r_cnt <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_push && w_pop_ok) begin
         // Return consumes the old top while the call takes its slot.
         r_mem[r_ptr] <= i_data;
      end else if (i_push) begin
         r_mem[w_ptr_inc] <= i_data;
         r_ptr            <= w_ptr_inc;
         if (!o_full) begin
            r_cnt <= r_cnt + c_cnt_one;
         end
      end else if (w_pop_ok) begin
         r_ptr <= w_ptr_dec;
         r_cnt <= r_cnt - c_cnt_one;
      end
   end

endmodule : ras

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
// Module : pc_gen
// Brief  : Fetch program-counter generator with stall/redirect/halt control.
//          Optional return-address stack enabled by macro PC_GEN_RAS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_gen
   import arc_pkg::*;
#(
   parameter int          AW        = 32,
   parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
   parameter logic [31:0] EXC_VEC   = DEFAULT_EXC_VEC,
   parameter int          RAS_DEPTH = 4
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_stall,
   input  logic          i_halt,
   input  logic          i_resume,
   input  logic          i_exc,
   input  logic          i_redir_valid,
   input  logic [AW-1:0] i_redir_pc,
   input  logic          i_call,
   input  logic [AW-1:0] i_call_ra,
   input  logic          i_ret,
   output logic [AW-1:0] o_pc,
   output logic [AW-1:0] o_pc_plus4,
   output logic          o_fetch_valid,
   output logic          o_ras_miss,
   output logic          o_misalign
);

   localparam logic [AW-1:0] c_reset_pc = RESET_VEC[AW-1:0];
   localparam logic [AW-1:0] c_exc_pc   = EXC_VEC[AW-1:0];
   localparam logic [AW-1:0] c_pc_inc   = PC_INC[AW-1:0];

   pc_state_t     r_state;
   pc_state_t     w_state_nxt;
   logic [AW-1:0] r_pc;
   logic [AW-1:0] w_pc_nxt;
   logic [AW-1:0] w_pc_seq;
   logic          r_fetch_valid;
   logic          r_ras_miss;
   logic          r_misalign;
   logic          w_ras_act;
   logic          w_ras_miss_nxt;
   logic          w_misalign_nxt;

   assign w_pc_seq   = r_pc + c_pc_inc;
   assign o_pc       = r_pc;
   assign o_pc_plus4 = w_pc_seq;

   // Stack updates follow the ID stage: frozen by stall unless the front end
   // is being redirected anyway; exceptions never touch the stack.
   assign w_ras_act = !i_exc && (i_redir_valid || (!i_stall && r_state == ST_RUN));

   assign w_misalign_nxt = !i_exc && i_redir_valid && (i_redir_pc[1:0] != 2'b00);

`ifdef PC_GEN_RAS_EN
   logic [AW-1:0] w_ras_top;
   logic          w_ras_empty;
   logic          w_ras_full;
   logic          w_unused_ras;

   ras #(
      .AW        (AW),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_call && w_ras_act),
      .i_pop   (i_ret && w_ras_act),
      .i_data  (i_call_ra),
      .o_top   (w_ras_top),
      .o_empty (w_ras_empty),
      .o_full  (w_ras_full)
   );

   assign w_unused_ras   = w_ras_full;
   assign w_ras_miss_nxt = i_ret && w_ras_act && w_ras_empty;
`else
   localparam int c_unused_depth = RAS_DEPTH;
   logic          w_unused_ras;

   assign w_unused_ras   = ^{i_call, i_call_ra, i_ret, w_ras_act};
   assign w_ras_miss_nxt = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_BOOT: w_state_nxt = ST_RUN;
         ST_RUN: begin
            if (i_halt && !i_exc && !i_redir_valid) begin
               w_state_nxt = ST_HALT;
            end
         end
         ST_HALT: begin
            if (i_resume || i_exc) begin
               w_state_nxt = ST_RUN;
            end
         end
         default: w_state_nxt = ST_BOOT;
      endcase
   end

   always_comb begin
      w_pc_nxt = w_pc_seq;
      if (i_exc) begin
         w_pc_nxt = c_exc_pc;
      end else if (i_redir_valid) begin
         w_pc_nxt = {i_redir_pc[AW-1:2], 2'b00};
      end else if (i_stall || r_state != ST_RUN) begin
         w_pc_nxt = r_pc;
`ifdef PC_GEN_RAS_EN
      end else if (i_ret && !w_ras_empty) begin
         w_pc_nxt = w_ras_top;
`endif
      end else begin
         w_pc_nxt = w_pc_seq;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= ST_BOOT;
         r_pc          <= c_reset_pc;
         r_fetch_valid <= 1'b0;
         r_ras_miss    <= 1'b0;
         r_misalign    <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_fetch_valid <= (w_state_nxt == ST_RUN);
         r_ras_miss    <= w_ras_miss_nxt;
         r_misalign    <= w_misalign_nxt;
      end
   end

   assign o_fetch_valid = r_fetch_valid;
   assign o_ras_miss    = r_ras_miss;
   assign o_misalign    = r_misalign;

endmodule : pc_gen

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
// Module : tb_pc_gen
// Brief  : Self-checking bench for pc_gen (directed table + random vs model).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_gen;

   localparam logic [31:0] RV    = 32'hBFC0_0000;
   localparam logic [31:0] EV    = 32'hBFC0_0380;
   localparam int          DEPTH = 4;
`ifdef PC_GEN_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 0, halt = 0, resume = 0, exc = 0, redir = 0, call = 0, ret = 0;
   logic [31:0] redir_pc = '0, call_ra = '0;
   logic [31:0] pc, pc4;
   logic        fv, miss, mis;

   logic        z1 = 1'b0;
   logic [7:0]  z8 = '0;
   logic [7:0]  pc8, pc8_4;
   logic        fv8, miss8, mis8;

   int total = 0;
   int bad   = 0;

   // Reference state
   logic [31:0] m_pc;
   int          m_mode;   // 0 boot, 1 run, 2 halt
   logic [31:0] m_ras[$];
   logic        m_miss, m_mis;

   always #5 clk = ~clk;

   pc_gen u_dut (
      .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_halt(halt), .i_resume(resume),
      .i_exc(exc), .i_redir_valid(redir), .i_redir_pc(redir_pc), .i_call(call),
      .i_call_ra(call_ra), .i_ret(ret), .o_pc(pc), .o_pc_plus4(pc4),
      .o_fetch_valid(fv), .o_ras_miss(miss), .o_misalign(mis)
   );

   pc_gen #(.AW(8), .RESET_VEC(32'h0000_00F0), .EXC_VEC(32'h0000_0080)) u_dut8 (
      .i_clk(clk), .i_rst(rst), .i_stall(z1), .i_halt(z1), .i_resume(z1),
      .i_exc(z1), .i_redir_valid(z1), .i_redir_pc(z8), .i_call(z1),
      .i_call_ra(z8), .i_ret(z1), .o_pc(pc8), .o_pc_plus4(pc8_4),
      .o_fetch_valid(fv8), .o_ras_miss(miss8), .o_misalign(mis8)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc   = RV;
      m_mode = 0;
      m_miss = 0;
      m_mis  = 0;
      m_ras.delete();
   endtask

   task automatic model_edge();
      logic [31:0] npc;
      bit act;
      m_mis  = 0;
      m_miss = 0;
      act = !exc && (redir || (!stall && m_mode == 1));
      if (exc)                                          npc = EV;
      else if (redir) begin
         npc   = redir_pc & ~32'h3;
         m_mis = (redir_pc[1:0] != 2'b00);
      end
      else if (stall || m_mode != 1)                    npc = m_pc;
      else if (RAS_ON && ret && m_ras.size() > 0)       npc = m_ras[$];
      else                                              npc = m_pc + 32'd4;
      if (RAS_ON && act) begin
         if (ret && m_ras.size() == 0) m_miss = 1;
         if (call && ret && m_ras.size() > 0) begin
            m_ras[$] = call_ra;
         end else begin
            if (ret && m_ras.size() > 0) void'(m_ras.pop_back());
            if (call) begin
               m_ras.push_back(call_ra);
               if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
         end
      end
      case (m_mode)
         0: m_mode = 1;
         1: if (halt && !exc && !redir) m_mode = 2;
         default: if (resume || exc) m_mode = 1;
      endcase
      m_pc = npc;
   endtask

   task automatic check_all();
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc4, m_pc + 32'd4);
      chk("fetch_valid", {31'd0, fv}, {31'd0, m_mode == 1});
      chk("ras_miss", {31'd0, miss}, {31'd0, m_miss});
      chk("misalign", {31'd0, mis}, {31'd0, m_mis});
   endtask

   task automatic step(input logic st, input logic ha, input logic re, input logic ex,
                       input logic rv, input logic [31:0] rpc, input logic ca,
                       input logic [31:0] cra, input logic rt);
      stall = st; halt = ha; resume = re; exc = ex; redir = rv;
      redir_pc = rpc; call = ca; call_ra = cra; ret = rt;
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, '0, 0, '0, 0);
   endtask

   task automatic check_in_reset(input string nm);
      chk({nm, "_pc"}, pc, RV);
      chk({nm, "_valid"}, {31'd0, fv}, 32'd0);
      chk({nm, "_miss"}, {31'd0, miss}, 32'd0);
      chk({nm, "_misalign"}, {31'd0, mis}, 32'd0);
   endtask

   // Asynchronous reset asserted between clock edges
   task automatic mid_reset();
      #3;
      rst = 1'b1;
      #1;
      check_in_reset("async_rst");
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   typedef struct {
      logic        st, ha, re, ex, rv;
      logic [31:0] rpc;
      logic [31:0] exp_pc;
      logic        exp_valid;
      logic        exp_mis;
   } vec_t;

   vec_t        tbl[16];
   logic [7:0]  d8_exp[5];

   initial begin
      tbl[0]  = '{0,0,0,0,0, 32'h0,        32'hBFC0_0000, 1, 0};
      tbl[1]  = '{0,0,0,0,0, 32'h0,        32'hBFC0_0004, 1, 0};
      tbl[2]  = '{0,0,0,0,0, 32'h0,        32'hBFC0_0008, 1, 0};
      tbl[3]  = '{0,0,0,0,0, 32'h0,        32'hBFC0_000C, 1, 0};
      tbl[4]  = '{0,0,0,0,0, 32'h0,        32'hBFC0_0010, 1, 0};
      tbl[5]  = '{1,0,0,0,0, 32'h0,        32'hBFC0_0010, 1, 0};
      tbl[6]  = '{1,0,0,0,0, 32'h0,        32'hBFC0_0010, 1, 0};
      tbl[7]  = '{1,0,0,0,0, 32'h0,        32'hBFC0_0010, 1, 0};
      tbl[8]  = '{0,0,0,0,0, 32'h0,        32'hBFC0_0014, 1, 0};
      tbl[9]  = '{1,0,0,0,1, 32'h0040_0002, 32'h0040_0000, 1, 1};
      tbl[10] = '{0,0,0,0,0, 32'h0,        32'h0040_0004, 1, 0};
      tbl[11] = '{0,0,0,1,1, 32'h0000_1234, 32'hBFC0_0380, 1, 0};
      tbl[12] = '{0,1,0,0,0, 32'h0,        32'hBFC0_0384, 0, 0};
      tbl[13] = '{0,0,0,0,0, 32'h0,        32'hBFC0_0384, 0, 0};
      tbl[14] = '{0,0,0,1,0, 32'h0,        32'hBFC0_0380, 1, 0};
      tbl[15] = '{0,0,0,0,0, 32'h0,        32'hBFC0_0384, 1, 0};
      d8_exp[0] = 8'hF0; d8_exp[1] = 8'hF4; d8_exp[2] = 8'hF8;
      d8_exp[3] = 8'hFC; d8_exp[4] = 8'h00;

      #2;
      rst = 1'b1;
      #1;
      check_in_reset("reset");
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_in_reset("reset_hold");
      chk("aw8_reset_pc", {24'd0, pc8}, 32'h0000_00F0);
      rst = 1'b0;
      #1;
      check_in_reset("boot");

      for (int i = 0; i < 16; i++) begin
         step(tbl[i].st, tbl[i].ha, tbl[i].re, tbl[i].ex, tbl[i].rv, tbl[i].rpc, 0, '0, 0);
         chk($sformatf("vec%0d_pc", i), pc, tbl[i].exp_pc);
         chk($sformatf("vec%0d_valid", i), {31'd0, fv}, {31'd0, tbl[i].exp_valid});
         chk($sformatf("vec%0d_misalign", i), {31'd0, mis}, {31'd0, tbl[i].exp_mis});
         if (i < 5) begin
            chk($sformatf("aw8_pc%0d", i), {24'd0, pc8}, {24'd0, d8_exp[i]});
            chk($sformatf("aw8_plus4_%0d", i), {24'd0, pc8_4}, {24'd0, d8_exp[i] + 8'd4});
         end
      end

`ifdef PC_GEN_RAS_EN
      for (int i = 1; i <= 5; i++) begin
         step(0, 0, 0, 0, 0, '0, 1, 32'h100 * i, 0);
      end
      for (int i = 0; i < 5; i++) begin
         logic [31:0] before;
         before = m_pc;
         step(0, 0, 0, 0, 0, '0, 0, '0, 1);
         if (i < 4) begin
            chk($sformatf("ras_pop%0d", i), pc, 32'h500 - 32'h100 * i);
            chk($sformatf("ras_pop%0d_miss", i), {31'd0, miss}, 32'd0);
         end else begin
            chk("ras_empty_seq", pc, before + 32'd4);
            chk("ras_empty_miss", {31'd0, miss}, 32'd1);
         end
      end
      step(0, 0, 0, 0, 0, '0, 1, 32'h100, 0);
      step(0, 0, 0, 0, 0, '0, 1, 32'h200, 0);
      step(0, 0, 0, 0, 0, '0, 1, 32'h600, 1);
      chk("ras_callret_tgt", pc, 32'h200);
      step(0, 0, 0, 0, 0, '0, 0, '0, 1);
      chk("ras_new_top", pc, 32'h600);
      step(0, 0, 0, 0, 0, '0, 0, '0, 1);
      chk("ras_below", pc, 32'h100);
      step(0, 0, 0, 0, 0, '0, 1, 32'h700, 0);
      mid_reset();
      idle();
      step(0, 0, 0, 0, 0, '0, 0, '0, 1);
      chk("ras_after_rst_pc", pc, RV + 32'd4);
      chk("ras_after_rst_miss", {31'd0, miss}, 32'd1);
`else
      mid_reset();
      idle();
      step(0, 0, 0, 0, 0, '0, 1, 32'h700, 1);
      chk("noras_ret_seq", pc, RV + 32'd4);
      chk("noras_miss", {31'd0, miss}, 32'd0);
`endif

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 249) == 0) begin
            mid_reset();
         end else begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 7) == 0, $urandom(),
                 $urandom_range(0, 3) == 0, $urandom() & ~32'h3,
                 $urandom_range(0, 3) == 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_pc_gen

`default_nettype wire
